// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one signed MAC walks the taps one per cycle, then
// holds the full-precision result until the consumer takes it.
module fir_mac_scheduler #(
   parameter int TAP_WIDTH = 8,
   parameter int NUM_TAPS  = 4,
   parameter int ACC_WIDTH = 2*TAP_WIDTH + $clog2(NUM_TAPS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [TAP_WIDTH-1:0]        sample_in,
   input  logic                        sample_valid,
   output logic                        sample_ready,
   output logic [ACC_WIDTH-1:0]        result_out,
   output logic                        result_valid,
   input  logic                        result_ready,
   input  logic                        cfg_we,
   input  logic [$clog2(NUM_TAPS)-1:0] cfg_addr,
   input  logic [TAP_WIDTH-1:0]        cfg_data,
   output logic                        cfg_ready,
   input  logic                        flush,
   output logic                        busy
);

   localparam int          ADDR_W = $clog2(NUM_TAPS);
   localparam int          PROD_W = 2*TAP_WIDTH;
   localparam int unsigned NT     = NUM_TAPS;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic signed [TAP_WIDTH-1:0] taps_q   [NUM_TAPS];
   logic signed [TAP_WIDTH-1:0] taps_d   [NUM_TAPS];
   logic signed [TAP_WIDTH-1:0] coeffs_q [NUM_TAPS];
   logic signed [TAP_WIDTH-1:0] coeffs_d [NUM_TAPS];
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0] res_q, res_d;
   logic [ADDR_W-1:0]           idx_q, idx_d;

   logic signed [TAP_WIDTH-1:0] tap_sel, coef_sel;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_WIDTH-1:0] prod_ext, acc_sum;
   logic                        idx_last;

   // Decoded selects keep the mux safe when NUM_TAPS is not a power of two.
   always_comb begin
      tap_sel  = '0;
      coef_sel = '0;
      for (int unsigned k = 0; k < NT; k++) begin
         if (idx_q == ADDR_W'(k)) begin
            tap_sel  = taps_q[k];
            coef_sel = coeffs_q[k];
         end
      end
      prod     = {{TAP_WIDTH{tap_sel[TAP_WIDTH-1]}}, tap_sel} *
                 {{TAP_WIDTH{coef_sel[TAP_WIDTH-1]}}, coef_sel};
      prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
      acc_sum  = acc_q + prod_ext;
      idx_last = (idx_q == ADDR_W'(NT-1));
   end

   always_comb begin
      state_d  = state_q;
      taps_d   = taps_q;
      coeffs_d = coeffs_q;
      acc_d    = acc_q;
      res_d    = res_q;
      idx_d    = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_we) begin
               // Out-of-range addresses match no entry, so the write is dropped.
               for (int unsigned k = 0; k < NT; k++) begin
                  if (cfg_addr == ADDR_W'(k)) coeffs_d[k] = cfg_data;
               end
            end else if (flush) begin
               for (int unsigned k = 0; k < NT; k++) taps_d[k] = '0;
            end else if (sample_valid) begin
               taps_d[0] = sample_in;
               for (int unsigned k = 1; k < NT; k++) taps_d[k] = taps_q[k-1];
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            acc_d = acc_sum;
            idx_d = idx_q + ADDR_W'(1);
            if (idx_last) begin
               res_d   = acc_sum;
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (result_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         res_q   <= '0;
         idx_q   <= '0;
         for (int unsigned k = 0; k < NT; k++) begin
            taps_q[k]   <= '0;
            coeffs_q[k] <= '0;
         end
         coeffs_q[0] <= TAP_WIDTH'(1);
      end else begin
         state_q  <= state_d;
         taps_q   <= taps_d;
         coeffs_q <= coeffs_d;
         acc_q    <= acc_d;
         res_q    <= res_d;
         idx_q    <= idx_d;
      end
   end

   assign cfg_ready    = rst && (state_q == S_IDLE);
   assign sample_ready = cfg_ready && !cfg_we && !flush;
   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign result_out   = res_q;

endmodule
